// File: rtl/muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_pkg
// Shared definitions for the multiply/divide sequencer: op codes, FSM state
// encoding, HI/LO mux select values and a small state-class helper.
// -----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

  // Op codes issued by control; 2'b1x is illegal
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;

  // HI/LO mux select values
  localparam logic SEL_DIV  = 1'b0;
  localparam logic SEL_MULT = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MULT_RUN = 3'd1,
    DIV_RUN  = 3'd2,
    WB       = 3'd3,
    EXC      = 3'd4
  } state_e;

  // True for the two states in which a unit is iterating
  function automatic logic is_run(input state_e s);
    return (s == MULT_RUN) || (s == DIV_RUN);
  endfunction

endpackage

// File: rtl/muldiv_timeout_cnt.sv
// -----------------------------------------------------------------------------
// muldiv_timeout_cnt
// Saturating cycle counter used to bound how long a RUN state may last.
// Ports:
//   clock_i     rising-edge clock
//   reset_i     synchronous active-high reset (clears the count)
//   clear_i     synchronous clear, priority over enable
//   en_i        count enable
//   count_o     current count, saturates at TIMEOUT_CYCLES
//   terminal_o  high while count_o == TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module muldiv_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             terminal_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  // Count register: clear wins, then increment until saturation
  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      count_q <= {CNT_W{1'b0}};
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o    = count_q;
  assign terminal_o = (count_q == CNT_TERM);

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Sequences the iterative multiplier/divider for one control request: pulses
// start, waits for the matching done, then commits HI/LO in a one-cycle WB
// state or reports div0/timeout in a one-cycle EXC state. All outputs are
// registered.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   op_valid, op_code            request strobe and op (00 MULT, 01 DIV)
//   flush                        abort any in-flight op, no commit
//   mult_done, div_done, div0    unit status
//   mult_start, div_start        one-cycle start pulses
//   hi_sel, lo_sel               HI/LO source (0 divider, 1 multiplier)
//   write_hi, write_lo, op_done  commit strobes (WB cycle)
//   busy                         stall to control (any state but IDLE)
//   exc_div0, exc_timeout        one-cycle exception pulses
//   op_err                       one-cycle illegal op_code pulse
//   cycle_count                  cycles elapsed in the current RUN state
// -----------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic             flush,
  input  logic             mult_done,
  input  logic             div_done,
  input  logic             div0,
  output logic             mult_start,
  output logic             div_start,
  output logic             hi_sel,
  output logic             lo_sel,
  output logic             write_hi,
  output logic             write_lo,
  output logic             busy,
  output logic             op_done,
  output logic             exc_div0,
  output logic             exc_timeout,
  output logic             op_err,
  output logic [CNT_W-1:0] cycle_count
);

  state_e state_q, state_d;
  logic   mult_start_q, div_start_q;
  logic   hi_sel_q, lo_sel_q;
  logic   write_q, op_done_q, busy_q;
  logic   exc_div0_q, exc_timeout_q, op_err_q;
  logic   exc_div0_d, exc_timeout_d, op_err_d;
  logic   cnt_clear_s, cnt_en_s, cnt_term_s;

  // Next-state decode; flush is tested first so it beats done/div0/timeout
  always_comb begin
    state_d       = state_q;
    exc_div0_d    = 1'b0;
    exc_timeout_d = 1'b0;
    op_err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid && !flush) begin
          if (op_code == OP_MULT) begin
            state_d = MULT_RUN;
          end else if (op_code == OP_DIV) begin
            state_d = DIV_RUN;
          end else begin
            op_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MULT_RUN: begin
        // mult_start_q marks the start cycle, where a done is stale
        if (flush) begin
          state_d = IDLE;
        end else if (mult_done && !mult_start_q) begin
          state_d = WB;
        end else if (cnt_term_s) begin
          state_d       = EXC;
          exc_timeout_d = 1'b1;
        end else begin
          state_d = MULT_RUN;
        end
      end
      DIV_RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (div0) begin
          state_d    = EXC;
          exc_div0_d = 1'b1;
        end else if (div_done && !div_start_q) begin
          state_d = WB;
        end else if (cnt_term_s) begin
          state_d       = EXC;
          exc_timeout_d = 1'b1;
        end else begin
          state_d = DIV_RUN;
        end
      end
      WB:      state_d = IDLE;
      EXC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter runs only while staying in RUN; entering IDLE or RUN zeroes it
  assign cnt_clear_s = (state_q == IDLE) || (state_d == IDLE);
  assign cnt_en_s    = is_run(state_q) && (state_d == state_q);

  muldiv_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout_cnt (
    .clock_i    (clock),
    .reset_i    (reset),
    .clear_i    (cnt_clear_s),
    .en_i       (cnt_en_s),
    .count_o    (cycle_count),
    .terminal_o (cnt_term_s)
  );

  // FSM state and registered outputs, all derived from the upcoming state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mult_start_q  <= 1'b0;
      div_start_q   <= 1'b0;
      hi_sel_q      <= 1'b0;
      lo_sel_q      <= 1'b0;
      write_q       <= 1'b0;
      op_done_q     <= 1'b0;
      busy_q        <= 1'b0;
      exc_div0_q    <= 1'b0;
      exc_timeout_q <= 1'b0;
      op_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mult_start_q <= (state_q == IDLE) && (state_d == MULT_RUN);
      div_start_q  <= (state_q == IDLE) && (state_d == DIV_RUN);
      // Selects are latched at accept and held through WB
      if ((state_q == IDLE) && is_run(state_d)) begin
        hi_sel_q <= (state_d == MULT_RUN) ? SEL_MULT : SEL_DIV;
        lo_sel_q <= (state_d == MULT_RUN) ? SEL_MULT : SEL_DIV;
      end else begin
        hi_sel_q <= hi_sel_q;
        lo_sel_q <= lo_sel_q;
      end
      write_q       <= (state_d == WB);
      op_done_q     <= (state_d == WB);
      busy_q        <= (state_d != IDLE);
      exc_div0_q    <= exc_div0_d;
      exc_timeout_q <= exc_timeout_d;
      op_err_q      <= op_err_d;
    end
  end

  assign mult_start  = mult_start_q;
  assign div_start   = div_start_q;
  assign hi_sel      = hi_sel_q;
  assign lo_sel      = lo_sel_q;
  assign write_hi    = write_q;
  assign write_lo    = write_q;
  assign op_done     = op_done_q;
  assign busy        = busy_q;
  assign exc_div0    = exc_div0_q;
  assign exc_timeout = exc_timeout_q;
  assign op_err      = op_err_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed bench: stimulus pushes the expected commit/exception event into a
// scoreboard queue; a negedge monitor pops and compares whenever the DUT shows
// op_done, exc_div0, exc_timeout or op_err. Cycle-level checks sit inline.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic [1:0] op_code = 2'b00;
  logic       flush = 1'b0;
  logic       mult_done = 1'b0;
  logic       div_done = 1'b0;
  logic       div0 = 1'b0;
  logic       mult_start, div_start, hi_sel, lo_sel, write_hi, write_lo;
  logic       busy, op_done, exc_div0, exc_timeout, op_err;
  logic [5:0] cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected event: {op_done, write_hi, write_lo, hi_sel, lo_sel, exc_div0, exc_timeout, op_err}
  typedef struct packed {
    logic [7:0] bits;
    logic [7:0] mask;
    logic       chk_cnt;
    logic [5:0] cnt;
    logic [7:0] tag;
  } exp_t;
  exp_t sb_q[$];

  localparam logic [7:0] EV_WB_MULT = 8'b1111_1000;
  localparam logic [7:0] EV_WB_DIV  = 8'b1110_0000;
  localparam logic [7:0] EV_DIV0    = 8'b0000_0100;
  localparam logic [7:0] EV_TMO_M   = 8'b0001_1010;
  localparam logic [7:0] EV_ERR     = 8'b0000_0001;
  localparam logic [7:0] MASK_ALL   = 8'hFF;
  localparam logic [7:0] MASK_NOSEL = 8'b1110_0111;

  wire [7:0] obits = {op_done, write_hi, write_lo, hi_sel, lo_sel, exc_div0, exc_timeout, op_err};
  wire [16:0] all_out = {obits, mult_start, div_start, busy, cycle_count};

  muldiv_sequencer #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .flush(flush), .mult_done(mult_done), .div_done(div_done), .div0(div0),
    .mult_start(mult_start), .div_start(div_start), .hi_sel(hi_sel), .lo_sel(lo_sel),
    .write_hi(write_hi), .write_lo(write_lo), .busy(busy), .op_done(op_done),
    .exc_div0(exc_div0), .exc_timeout(exc_timeout), .op_err(op_err),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] c);
    op_valid = 1'b1;
    op_code  = c;
    step();
    op_valid = 1'b0;
    op_code  = 2'b00;
  endtask

  task automatic push(input logic [7:0] b, input logic [7:0] m, input logic cc,
                      input logic [5:0] cnt, input logic [7:0] tag);
    exp_t e;
    e.bits = b; e.mask = m; e.chk_cnt = cc; e.cnt = cnt; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: compare each presented event against the scoreboard head
  always @(negedge clock) begin
    exp_t e;
    if ((op_done === 1'b1) || (exc_div0 === 1'b1) || (exc_timeout === 1'b1) || (op_err === 1'b1)) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got %b expected none (t=%0t)", obits, $time);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("event%0d_bits", e.tag), {24'd0, obits & e.mask}, {24'd0, e.bits & e.mask});
        if (e.chk_cnt) chk($sformatf("event%0d_count", e.tag), {26'd0, cycle_count}, {26'd0, e.cnt});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for edges 1 and 2
    step(); step();
    chk("reset_state", {15'd0, all_out}, 32'd0);
    reset = 1'b0;

    // MULT normal path: accept at edge 3, done at edge 36
    issue(2'b00);                                  // cycle 4
    chk("t1_mult_start_c4", {31'd0, mult_start}, 32'd1);
    chk("t1_busy_c4", {31'd0, busy}, 32'd1);
    chk("t1_cnt_c4", {26'd0, cycle_count}, 32'd0);
    chk("t1_hisel_c4", {31'd0, hi_sel}, 32'd1);
    for (int c = 5; c <= 36; c++) begin
      step();                                      // cycle c
      chk("t1_mult_start_low", {31'd0, mult_start}, 32'd0);
      chk("t1_busy_run", {31'd0, busy}, 32'd1);
      if (c == 36) begin
        mult_done = 1'b1;
        push(EV_WB_MULT, MASK_ALL, 1'b0, 6'd0, 8'd1);
      end
    end
    step(); mult_done = 1'b0;                      // cycle 37 (WB)
    chk("t1_busy_c37", {31'd0, busy}, 32'd1);
    chk("t1_write_c37", {31'd0, write_hi}, 32'd1);
    step();                                        // cycle 38
    chk("t1_busy_c38", {31'd0, busy}, 32'd0);
    chk("t1_write_c38", {31'd0, write_hi}, 32'd0);

    // DIV with div0 two cycles after the start cycle
    issue(2'b01);
    chk("t2_div_start", {31'd0, div_start}, 32'd1);
    chk("t2_sel_div", {30'd0, hi_sel, lo_sel}, 32'd0);
    step();
    chk("t2_div_start_low", {31'd0, div_start}, 32'd0);
    chk("t2_write_low_a", {30'd0, write_hi, write_lo}, 32'd0);
    step();
    chk("t2_write_low_b", {30'd0, write_hi, write_lo}, 32'd0);
    div0 = 1'b1;
    push(EV_DIV0, MASK_ALL, 1'b0, 6'd0, 8'd2);
    step(); div0 = 1'b0;                           // EXC cycle
    chk("t2_busy_exc", {31'd0, busy}, 32'd1);
    step();                                        // IDLE
    chk("t2_exc_one_cycle", {31'd0, exc_div0}, 32'd0);
    chk("t2_busy_idle", {31'd0, busy}, 32'd0);

    // Immediate re-accept, then div0 together with div_done
    issue(2'b01);
    chk("t3_reaccept", {30'd0, busy, div_start}, 32'd3);
    step();
    div0 = 1'b1; div_done = 1'b1;
    push(EV_DIV0, MASK_ALL, 1'b0, 6'd0, 8'd3);
    step(); div0 = 1'b0; div_done = 1'b0;          // EXC cycle
    chk("t3_no_commit", {30'd0, write_hi, op_done}, 32'd0);
    step();

    // Illegal op_code in IDLE
    push(EV_ERR, MASK_NOSEL, 1'b0, 6'd0, 8'd4);
    issue(2'b10);
    chk("t3_err_busy", {31'd0, busy}, 32'd0);
    step();
    chk("t3_err_one_cycle", {30'd0, op_err, busy}, 32'd0);

    // Timeout: mult_done never arrives
    issue(2'b00);
    for (int k = 1; k <= 39; k++) begin
      step();
      chk("t4_cnt_below_40", {31'd0, (cycle_count < 6'd40)}, 32'd1);
      if (k == 39) begin
        chk("t4_cnt_39", {26'd0, cycle_count}, 32'd39);
        push(EV_TMO_M, MASK_ALL, 1'b1, 6'd39, 8'd5);
      end
    end
    step();                                        // EXC cycle
    chk("t4_cnt_exc", {26'd0, cycle_count}, 32'd39);
    step();
    chk("t4_tmo_one_cycle", {30'd0, exc_timeout, busy}, 32'd0);

    // Timeout edge with mult_done present: WB wins
    issue(2'b00);
    for (int k = 1; k <= 39; k++) begin
      step();
      if (k == 39) begin
        mult_done = 1'b1;
        push(EV_WB_MULT, MASK_ALL, 1'b1, 6'd39, 8'd6);
      end
    end
    step(); mult_done = 1'b0;                      // WB cycle
    chk("t4b_no_timeout", {31'd0, exc_timeout}, 32'd0);
    step();

    // flush at DIV_RUN count 10 with div_done; op_valid while busy ignored
    issue(2'b01);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 5) begin
        op_valid = 1'b1; op_code = 2'b00;
      end
      if (k == 6) begin
        op_valid = 1'b0;
        chk("t5_busy_ignored", {29'd0, mult_start, div_start, busy}, 32'd1);
      end
      if (k == 10) begin
        chk("t5_cnt_10", {26'd0, cycle_count}, 32'd10);
        flush = 1'b1; div_done = 1'b1;
      end
    end
    step(); flush = 1'b0; div_done = 1'b0;
    chk("t5_flush_idle", {29'd0, busy, write_hi, op_done}, 32'd0);
    step();
    chk("t5_flush_quiet", {29'd0, busy, write_hi, op_done}, 32'd0);

    // reset in the middle of MULT_RUN at count 15
    issue(2'b00);
    for (int k = 1; k <= 15; k++) step();
    chk("t6_cnt_15", {26'd0, cycle_count}, 32'd15);
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("t6_reset_outputs", {15'd0, all_out}, 32'd0);
    mult_done = 1'b1;
    step(); mult_done = 1'b0;
    chk("t6_stray_done", {30'd0, write_hi, busy}, 32'd0);
    step();
    chk("t6_no_op_done", {31'd0, op_done}, 32'd0);

    step(); step();
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
